// File: rtl/adc_cfg_sequencer.sv
// Table-driven feeder for the ADC serial config machine: walks host-loaded register
// writes, issues each one, polls completion and spaces entries with a CS-high gap.
`timescale 1ns/1ps
module adc_cfg_sequencer #(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int TIMEOUT    = 4096,
    parameter int GAP_CYCLES = 8
) (
    input  logic          CLK,
    input  logic          RSTb,
    input  logic          TBL_WE,
    input  logic [AW-1:0] TBL_ADDR,
    input  logic [25:0]   TBL_WDATA,
    input  logic [AW:0]   SEQ_LEN,
    input  logic          START,
    input  logic          ABORT,
    output logic          CFG_CEb,
    output logic          CFG_WEb,
    output logic [31:0]   CFG_DATA,
    input  logic [31:0]   CFG_STATUS,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
    output logic [1:0]    ERR_CODE,
    output logic [AW-1:0] CUR_IDX
);

    localparam logic [2:0] stIdle   = 3'd0;
    localparam logic [2:0] stLoad   = 3'd1;
    localparam logic [2:0] stIssue  = 3'd2;
    localparam logic [2:0] stCheck  = 3'd3;
    localparam logic [2:0] stWait   = 3'd4;
    localparam logic [2:0] stDelay  = 3'd5;
    localparam logic [2:0] stGap    = 3'd6;
    localparam logic [2:0] stFinish = 3'd7;

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [TW-1:0] toLast   = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] gapLast  = GW'(GAP_CYCLES - 1);
    localparam logic [AW:0]   depthLen = (AW + 1)'(DEPTH);

    logic [2:0]    state;
    logic [25:0]   tbl [DEPTH];
    logic [25:0]   entry;
    logic [1:0]    curSel;
    logic [AW:0]   seqLen;
    logic [15:0]   delayCnt;
    logic [TW-1:0] toCnt;
    logic [GW-1:0] gapCnt;
    logic [1:0]    statBusy;
    logic          unusedStatus;

    assign entry        = tbl[CUR_IDX];
    assign statBusy     = CFG_STATUS[31:30];
    assign unusedStatus = ^CFG_STATUS[29:0];

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            tbl <= '{default: '0};
        end else if (TBL_WE && !BUSY) begin
            tbl[TBL_ADDR] <= TBL_WDATA;
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state    <= stIdle;
            CFG_CEb  <= 1'b1;
            CFG_WEb  <= 1'b1;
            CFG_DATA <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            ERR_CODE <= '0;
            CUR_IDX  <= '0;
            curSel   <= '0;
            seqLen   <= '0;
            delayCnt <= '0;
            toCnt    <= '0;
            gapCnt   <= '0;
        end else if (ABORT && state != stIdle) begin
            state   <= stIdle;
            BUSY    <= 1'b0;
            CFG_CEb <= 1'b1;
            CFG_WEb <= 1'b1;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            case (state)
                stIdle: begin
                    if (START) begin
                        DONE     <= 1'b0;
                        ERR      <= 1'b0;
                        ERR_CODE <= '0;
                        CUR_IDX  <= '0;
                        if (SEQ_LEN == '0) begin
                            state <= stFinish;
                        end else begin
                            seqLen <= (SEQ_LEN > depthLen) ? depthLen : SEQ_LEN;
                            BUSY   <= 1'b1;
                            state  <= stLoad;
                        end
                    end
                end
                stLoad: begin
                    curSel <= entry[25:24];
                    if (entry[25:24] == 2'b00) begin
                        delayCnt <= entry[15:0];
                        state    <= stDelay;
                    end else begin
                        // strobes are set here so they are low exactly while in ISSUE
                        CFG_CEb  <= 1'b0;
                        CFG_WEb  <= 1'b0;
                        CFG_DATA <= {entry[25:24], 6'b0, entry[23:0]};
                        state    <= stIssue;
                    end
                end
                stIssue: begin
                    CFG_CEb <= 1'b1;
                    CFG_WEb <= 1'b1;
                    state   <= stCheck;
                end
                stCheck: begin
                    if (statBusy == curSel) begin
                        toCnt <= '0;
                        state <= stWait;
                    end else begin
                        ERR      <= 1'b1;
                        ERR_CODE <= 2'b01;
                        state    <= stFinish;
                    end
                end
                stWait: begin
                    if (statBusy == 2'b00) begin
                        gapCnt <= '0;
                        state  <= stGap;
                    end else if (toCnt == toLast) begin
                        ERR      <= 1'b1;
                        ERR_CODE <= 2'b10;
                        state    <= stFinish;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                stDelay: begin
                    if (delayCnt == '0) begin
                        gapCnt <= '0;
                        state  <= stGap;
                    end else begin
                        delayCnt <= delayCnt - 1'b1;
                    end
                end
                stGap: begin
                    if (gapCnt == gapLast) begin
                        if ({1'b0, CUR_IDX} == seqLen - 1'b1) begin
                            state <= stFinish;
                        end else begin
                            CUR_IDX <= CUR_IDX + 1'b1;
                            state   <= stLoad;
                        end
                    end else begin
                        gapCnt <= gapCnt + 1'b1;
                    end
                end
                stFinish: begin
                    BUSY <= 1'b0;
                    if (!ERR) DONE <= 1'b1;
                    state <= stIdle;
                end
                default: state <= stIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Bench for adc_cfg_sequencer: a reactive config-machine model plus a timeline model
// built from per-entry latency arithmetic, compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_adc_cfg_sequencer;

    localparam int G    = 8;
    localparam int TO   = 4096;
    localparam int MAXR = 4300;
    localparam logic [29:0] LOWBITS = 30'h15A5A5A5;

    logic        CLK, RSTb, TBL_WE, START, ABORT;
    logic [3:0]  TBL_ADDR;
    logic [25:0] TBL_WDATA;
    logic [4:0]  SEQ_LEN;
    logic        CFG_CEb, CFG_WEb, BUSY, DONE, ERR;
    logic [31:0] CFG_DATA, CFG_STATUS;
    logic [1:0]  ERR_CODE;
    logic [3:0]  CUR_IDX;

    adc_cfg_sequencer #(.DEPTH(16), .AW(4), .TIMEOUT(TO), .GAP_CYCLES(G)) dut (
        .CLK(CLK), .RSTb(RSTb), .TBL_WE(TBL_WE), .TBL_ADDR(TBL_ADDR), .TBL_WDATA(TBL_WDATA),
        .SEQ_LEN(SEQ_LEN), .START(START), .ABORT(ABORT), .CFG_CEb(CFG_CEb), .CFG_WEb(CFG_WEb),
        .CFG_DATA(CFG_DATA), .CFG_STATUS(CFG_STATUS), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .ERR_CODE(ERR_CODE), .CUR_IDX(CUR_IDX)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int nChecks = 0;
    int nFail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Config machine model: per issued write, accept (busy for B cycles), ignore, or hang.
    int   cfgKind [8];
    int   cfgB    [8];
    int   cfgN, cfgRem;
    bit   cfgHang, strobeSeen;
    logic [1:0] selSeen;

    initial begin : cfgModel
        forever begin
            @(negedge CLK);
            strobeSeen = !CFG_CEb && !CFG_WEb;
            selSeen    = CFG_DATA[31:30];
            @(posedge CLK);
            #1;
            if (strobeSeen) begin
                if (cfgKind[cfgN] == 0) begin
                    CFG_STATUS = {selSeen, LOWBITS};
                    cfgRem     = cfgB[cfgN];
                end else if (cfgKind[cfgN] == 2) begin
                    CFG_STATUS = {selSeen, LOWBITS};
                    cfgHang    = 1'b1;
                end
                cfgN++;
            end else if (!cfgHang && cfgRem > 0) begin
                cfgRem--;
                if (cfgRem == 0) CFG_STATUS = {2'b00, LOWBITS};
            end
        end
    end

    task automatic cfgClear();
        @(negedge CLK);
        CFG_STATUS = {2'b00, LOWBITS};
        cfgHang = 1'b0;
        cfgRem  = 0;
        cfgN    = 0;
    endtask

    task automatic setMode(input int k, input int kind, input int b);
        cfgKind[k] = kind;
        cfgB[k]    = b;
    endtask

    // Expected timeline, indexed by cycles after the START edge
    bit          expCe   [MAXR];
    bit          expBusy [MAXR];
    bit          expDone [MAXR];
    bit          expErr  [MAXR];
    logic [31:0] expData [MAXR];
    int          span;
    logic [31:0] modelData;
    logic [25:0] shTbl [16];
    int          issueSeen [$];
    int          cyc = 0;
    int          startCyc = 0;
    bit          chkOn = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic plan(input int len);
        int t, f, n;
        bit err, stop;
        logic [1:0]  sel;
        logic [31:0] d;
        int          iss [$];
        logic [31:0] dat [$];
        t = 0; f = 0; n = 0; err = 0; stop = 0;
        for (int i = 0; i < len && !stop; i++) begin
            sel = shTbl[i][25:24];
            if (sel == 2'b00) begin
                t = t + 2 + int'(shTbl[i][15:0]) + G;
            end else begin
                iss.push_back(t + 1);
                dat.push_back({sel, 6'b0, shTbl[i][23:0]});
                if (cfgKind[n] == 1) begin
                    f = t + 3; err = 1; stop = 1;
                end else if (cfgKind[n] == 2) begin
                    f = t + 3 + TO; err = 1; stop = 1;
                end else begin
                    t = t + 3 + cfgB[n] + G;
                end
                n++;
            end
        end
        if (!stop) f = t;
        span = f + 4;
        d = modelData;
        for (int r = 0; r < span; r++) begin
            expCe[r] = 1'b1;
            foreach (iss[k]) if (iss[k] == r) begin
                expCe[r] = 1'b0;
                d = dat[k];
            end
            expData[r] = d;
            expBusy[r] = (len != 0) && (r <= f);
            expDone[r] = !err && (r >= f + 1);
            expErr[r]  = err && (r >= f);
        end
        modelData = d;
    endtask

    always @(negedge CLK) begin : compare
        int rel;
        if (chkOn) begin
            rel = cyc - startCyc;
            if (rel >= 0 && rel < span) begin
                chk("cfg_ceb",  32'(CFG_CEb), 32'(expCe[rel]));
                chk("cfg_web",  32'(CFG_WEb), 32'(expCe[rel]));
                chk("cfg_data", CFG_DATA,     expData[rel]);
                chk("busy",     32'(BUSY),    32'(expBusy[rel]));
                chk("done",     32'(DONE),    32'(expDone[rel]));
                chk("err",      32'(ERR),     32'(expErr[rel]));
                if (!CFG_CEb) issueSeen.push_back(rel);
            end
        end
    end

    task automatic tblWrite(input logic [3:0] a, input logic [25:0] d);
        @(negedge CLK);
        TBL_WE = 1'b1; TBL_ADDR = a; TBL_WDATA = d;
        @(negedge CLK);
        TBL_WE = 1'b0;
        shTbl[a] = d;
    endtask

    task automatic runSeq(input int len, input int abortAt, input int wrAt, input int rstAt);
        int rel;
        plan(len);
        if (abortAt >= 0) begin
            for (int r = abortAt + 1; r < abortAt + 30; r++) begin
                expCe[r] = 1'b1; expBusy[r] = 1'b0; expDone[r] = 1'b0; expErr[r] = 1'b0;
                expData[r] = expData[abortAt];
            end
            span = abortAt + 30;
            modelData = expData[abortAt];
        end
        cfgN = 0;
        @(negedge CLK);
        SEQ_LEN = 5'(len); START = 1'b1; startCyc = cyc + 1;
        issueSeen.delete();
        chkOn = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        rel = cyc - startCyc;
        while (rel < span) begin
            ABORT  = (rel == abortAt);
            TBL_WE = (rel == wrAt);
            if (rel == wrAt) begin
                TBL_ADDR = 4'd1; TBL_WDATA = 26'h3FFFFFF;
            end
            if (rel == rstAt) begin
                #2;
                RSTb  = 1'b0;
                chkOn = 1'b0;
                break;
            end
            @(negedge CLK);
            rel = cyc - startCyc;
        end
        ABORT = 1'b0; TBL_WE = 1'b0; chkOn = 1'b0;
    endtask

    task automatic chkIssues(input string tag, input int cnt, input int a, input int b);
        chk({tag, "_issue_count"}, 32'(issueSeen.size()), 32'(cnt));
        if (cnt >= 1 && issueSeen.size() >= 1) chk({tag, "_issue0_rel"}, 32'(issueSeen[0]), 32'(a));
        if (cnt >= 2 && issueSeen.size() >= 2) chk({tag, "_issue1_rel"}, 32'(issueSeen[1]), 32'(b));
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        RSTb = 1'b0; TBL_WE = 1'b0; TBL_ADDR = '0; TBL_WDATA = '0; SEQ_LEN = '0;
        START = 1'b0; ABORT = 1'b0; CFG_STATUS = {2'b00, LOWBITS};
        modelData = '0; shTbl = '{default: '0};
        cfgN = 0; cfgRem = 0; cfgHang = 1'b0;
        for (int k = 0; k < 8; k++) setMode(k, 0, 10);
        repeat (3) @(negedge CLK);
        chk("rst_ceb", 32'(CFG_CEb), 32'd1);
        chk("rst_web", 32'(CFG_WEb), 32'd1);
        chk("rst_data", CFG_DATA, 32'h0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_idx", 32'(CUR_IDX), 32'd0);
        RSTb = 1'b1;

        // two single-ADC writes
        tblWrite(4'd0, 26'h1123456);
        tblWrite(4'd1, 26'h2ABCDEF);
        setMode(0, 0, 50); setMode(1, 0, 50);
        runSeq(2, -1, -1, -1);
        chkIssues("t1", 2, 1, 62);
        chk("t1_done", 32'(DONE), 32'd1);
        chk("t1_err", 32'(ERR), 32'd0);
        chk("t1_idx", 32'(CUR_IDX), 32'd1);
        chk("t1_data", CFG_DATA, 32'h80ABCDEF);

        // both ADCs
        tblWrite(4'd0, 26'h300FF00);
        setMode(0, 0, 50);
        runSeq(1, -1, -1, -1);
        chkIssues("t2", 1, 1, 0);
        chk("t2_data", CFG_DATA, 32'hC000FF00);
        chk("t2_done", 32'(DONE), 32'd1);

        // delay entry of 16 between writes
        tblWrite(4'd0, 26'h1111111);
        tblWrite(4'd1, 26'h0000010);
        tblWrite(4'd2, 26'h2222222);
        setMode(0, 0, 20); setMode(1, 0, 20);
        runSeq(3, -1, -1, -1);
        chkIssues("t3", 2, 1, 58);
        chk("t3_idx", 32'(CUR_IDX), 32'd2);
        chk("t3_data", CFG_DATA, 32'h80222222);

        // busy never clears on the second write
        tblWrite(4'd0, 26'h1AAAAAA);
        tblWrite(4'd1, 26'h2BBBBBB);
        setMode(0, 0, 10); setMode(1, 2, 0);
        runSeq(2, -1, -1, -1);
        chkIssues("t4", 2, 1, 22);
        chk("t4_err", 32'(ERR), 32'd1);
        chk("t4_code", 32'(ERR_CODE), 32'd2);
        chk("t4_idx", 32'(CUR_IDX), 32'd1);
        chk("t4_done", 32'(DONE), 32'd0);
        cfgClear();

        // write ignored
        tblWrite(4'd0, 26'h2000123);
        setMode(0, 1, 0);
        runSeq(1, -1, -1, -1);
        chkIssues("t5", 1, 1, 0);
        chk("t5_code", 32'(ERR_CODE), 32'd1);
        chk("t5_idx", 32'(CUR_IDX), 32'd0);
        chk("t5_err", 32'(ERR), 32'd1);
        cfgClear();

        // empty sequence
        runSeq(0, -1, -1, -1);
        chkIssues("t6", 0, 0, 0);
        chk("t6_done", 32'(DONE), 32'd1);
        chk("t6_err", 32'(ERR), 32'd0);

        // abort while waiting for completion
        tblWrite(4'd0, 26'h1000077);
        setMode(0, 2, 0);
        runSeq(1, 20, -1, -1);
        chkIssues("t7", 1, 1, 0);
        chk("t7_busy", 32'(BUSY), 32'd0);
        chk("t7_err", 32'(ERR), 32'd0);
        chk("t7_done", 32'(DONE), 32'd0);
        cfgClear();

        // table write attempted while busy must be dropped
        tblWrite(4'd0, 26'h10000AA);
        tblWrite(4'd1, 26'h20000BB);
        setMode(0, 0, 30);
        runSeq(1, -1, 10, -1);
        chkIssues("t8a", 1, 1, 0);
        setMode(0, 0, 5); setMode(1, 0, 5);
        runSeq(2, -1, -1, -1);
        chkIssues("t8b", 2, 1, 17);
        chk("t8_data", CFG_DATA, 32'h800000BB);

        // asynchronous reset during ISSUE
        tblWrite(4'd0, 26'h1000099);
        setMode(0, 2, 0);
        runSeq(1, -1, -1, 1);
        #1;
        chk("t9_ceb", 32'(CFG_CEb), 32'd1);
        chk("t9_web", 32'(CFG_WEb), 32'd1);
        chk("t9_data", CFG_DATA, 32'h0);
        chk("t9_busy", 32'(BUSY), 32'd0);
        chk("t9_done", 32'(DONE), 32'd0);
        chk("t9_err", 32'(ERR), 32'd0);
        chk("t9_code", 32'(ERR_CODE), 32'd0);
        chk("t9_idx", 32'(CUR_IDX), 32'd0);
        chkIssues("t9", 1, 1, 0);
        repeat (2) @(negedge CLK);
        RSTb = 1'b1;
        cfgClear();
        shTbl = '{default: '0};
        modelData = '0;
        // cleared table: entry 0 is now a zero-length delay
        runSeq(1, -1, -1, -1);
        chkIssues("t9b", 0, 0, 0);
        chk("t9b_done", 32'(DONE), 32'd1);
        chk("t9b_idx", 32'(CUR_IDX), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/adc_cfg_sequencer.md
Name: adc_cfg_sequencer

Overview:
- Upstream feeder for the ADC serial configuration machine. Holds a host-loaded table of ADC register writes.
- On START, it walks the table and, for each entry, issues one write on the machine's CEb/WEb/DATA interface.
- It then polls the machine's status word until serialization completes, and inserts a programmable CS-high gap before the next entry.
- Lets firmware program both ADCs with a single command instead of polling each word from VME.

Parameters:
- DEPTH, 16, number of table entries (power of 2, max 32)
- AW, 4, table address width, log2(DEPTH)
- TIMEOUT, 4096, max CLK cycles allowed in WAIT_DONE before error
- GAP_CYCLES, 8, CLK cycles idle between consecutive entries (CS high time)

Ports:
- CLK  in  1  system clock
- RSTb  in  1  reset
- TBL_WE  in  1  table write strobe, active high
- TBL_ADDR  in  AW  table write address
- TBL_WDATA  in  26  entry: [25:24] sel (01=ADC1, 10=ADC2, 11=both, 00=delay), [23:0] serial word or delay count
- SEQ_LEN  in  AW+1  number of entries to run, 0..DEPTH; sampled on START
- START  in  1  one-cycle start pulse
- ABORT  in  1  one-cycle abort pulse
- CFG_CEb  out  1  chip enable to config machine, active low
- CFG_WEb  out  1  write enable to config machine, active low
- CFG_DATA  out  32  {sel[1], sel[0], 6'b0, word[23:0]}
- CFG_STATUS  in  32  config machine status; bits [31:30] are the busy flags
- BUSY  out  1  sequence in progress
- DONE  out  1  sticky: last sequence completed without error
- ERR  out  1  sticky: last sequence aborted by error
- ERR_CODE  out  2  01 = write not accepted, 10 = timeout
- CUR_IDX  out  AW  index of the entry being processed or failed

Behaviour:

Reset:
- Reset is asynchronous, active-low RSTb; clock is CLK.
- During reset: CFG_CEb=1, CFG_WEb=1, CFG_DATA=0, BUSY=0, DONE=0, ERR=0, ERR_CODE=0, CUR_IDX=0, all table entries=0, FSM in IDLE.
- Reset mid-sequence forces these values immediately. A serialization already under way in the config machine finishes on its own.

Table:
- Written at posedge CLK when TBL_WE=1 and BUSY=0. Writes while BUSY=1 are dropped.
- Addresses at or above DEPTH cannot occur, since AW bounds them.

FSM states: IDLE, LOAD, ISSUE, CHECK, WAIT_DONE, DELAY, GAP, FINISH.
- IDLE: on START, clear DONE/ERR/ERR_CODE and set CUR_IDX=0.
  - SEQ_LEN=0: go to FINISH.
  - Otherwise: latch the length, set BUSY=1, go to LOAD.
  - START while not in IDLE is ignored.
- LOAD (1 cycle): fetch entry[CUR_IDX].
  - sel=00: load the delay counter with word[15:0] and go to DELAY.
  - Otherwise: go to ISSUE.
- ISSUE (exactly 1 cycle): CFG_CEb=0, CFG_WEb=0, CFG_DATA driven. Go to CHECK.
- CHECK (1 cycle):
  - CFG_STATUS[31:30]==sel: clear the timeout counter, go to WAIT_DONE.
  - Otherwise: ERR=1, ERR_CODE=01, go to FINISH.
- WAIT_DONE: count CLK cycles.
  - CFG_STATUS[31:30]==00: go to GAP.
  - Counter reaches TIMEOUT first: ERR=1, ERR_CODE=10, go to FINISH.
- DELAY: decrement each cycle and go to GAP when the count is 0. A delay of 0 gives 1 cycle in DELAY.
- GAP: hold for GAP_CYCLES cycles, then:
  - CUR_IDX==len-1: go to FINISH.
  - Otherwise: CUR_IDX+1, go to LOAD.
- FINISH (1 cycle): BUSY=0. DONE=1 if ERR=0. Go to IDLE. CUR_IDX holds the last or failing index.

Other rules:
- ABORT in any non-IDLE state forces IDLE next cycle: BUSY=0, strobes high, DONE=0, ERR=0. ABORT has priority over every other transition.
- Outputs are registered. CFG_CEb/CFG_WEb are low only during ISSUE.
- CFG_DATA holds its value until the next ISSUE.
- Sequence latency per ADC entry = 1 (LOAD) + 1 (ISSUE) + 1 (CHECK) + WAIT_DONE + GAP_CYCLES.

Test Plan:
- Load entry0=0x1_123456 and entry1=0x2_ABCDEF, SEQ_LEN=2, START; the config model clears busy after 50 cycles -> two ISSUE strobes with CFG_DATA=0x40123456 then 0x80ABCDEF, at least 8 idle cycles between them, DONE=1, ERR=0, BUSY=0.
- Entry0=0x3_00FF00 (both ADCs) -> CHECK sees status[31:30]=11, CFG_DATA=0xC000FF00, DONE=1.
- Delay entry 0x0_000010 between two writes -> 17 DELAY cycles plus the gap before the second ISSUE.
- Config model never clears busy -> ERR=1, ERR_CODE=10 after 4096 WAIT_DONE cycles, CUR_IDX=failing index, DONE=0.
- Model ignores the write (status stays 00) -> ERR_CODE=01 in CHECK.
- SEQ_LEN=0 START -> DONE=1 two cycles later, no strobe.
- ABORT during WAIT_DONE -> BUSY=0 next cycle, no further strobes.
- TBL_WE while BUSY -> table unchanged.
- RSTb low mid-sequence -> all outputs return to reset values asynchronously.
